iob_rx_edge_capture: RTL and testbench
======================================

// Module: iob_rx_edge_capture
// PURPOSE
//   Receive-side counterpart of the output-pad fuzz designs. Takes PADDI from a
//   single input/bidir IO primitive, synchronises and glitch-filters it, and
//   reports each qualified edge as a timestamped event on a valid/ready port.
//   Sits between the IO primitive and the on-chip test logic in hardware
//   bring-up designs that check IO_TYPE/BANK_VCCIO configurations.
// PARAMETERS
//   SYNC_STAGES    2   flops in the synchroniser chain (legal range 2..4)
//   FILTER_CYCLES  4   consecutive stable cycles required to accept a new level (1..255)
//   TS_WIDTH       16  free-running timestamp width; wraps modulo 2**TS_WIDTH
//   CNT_WIDTH      16  accepted-edge counter width
// PORTS
//   clk           in   1          single clock domain
//   rst_n         in   1          asynchronous assert, active-low reset
//   paddi         in   1          raw pad input (PADDI); asynchronous to clk
//   en            in   1          1 = filter and capture active
//   evt_valid     out  1          event holding register full
//   evt_ready     in   1          consumer accepts the event when evt_valid & evt_ready
//   evt_rise      out  1          1 = rising edge, 0 = falling edge
//   evt_ts        out  TS_WIDTH   timestamp of the cycle in which level changed
//   level         out  1          filtered pad level
//   edge_count    out  CNT_WIDTH  accepted edges; wraps modulo 2**CNT_WIDTH
//   overflow      out  1          sticky: an edge was dropped because the holding register was full
//   clr_overflow  in   1          clears overflow
// BEHAVIOUR
//   Reset: all sync flops, level, evt_valid, evt_rise, evt_ts, edge_count,
//     overflow, timestamp and filter counter = 0; filter FSM = STABLE.
//   Timestamp ts increments every cycle regardless of en; wraps 0xFFFF -> 0x0000.
//   Synchroniser: plain SYNC_STAGES-flop chain; s = last stage output.
//   Filter FSM (only when en = 1):
//     STABLE:  s == level -> stay; s != level -> QUALIFY, fcnt = 1.
//     QUALIFY: s == level -> STABLE, fcnt = 0 (glitch rejected);
//              s != level & fcnt == FILTER_CYCLES-1 -> level <= s, STABLE, fcnt = 0;
//              otherwise fcnt++.
//     With FILTER_CYCLES = 1, a change in s is accepted on the first cycle it is seen.
//   en = 0: FSM forced to STABLE, fcnt = 0, level holds, no new events;
//     a pending event stays valid until consumed.
//   Latency: a clean paddi step becomes level after SYNC_STAGES + FILTER_CYCLES
//     clk edges (+1 on sampling uncertainty). evt_valid rises the same cycle as level.
//   Event on accept: evt_rise = new level, evt_ts = ts value in that cycle,
//     edge_count++ (always, including dropped events).
//   Holding register: loaded when an edge is accepted and (!evt_valid | evt_ready).
//     A simultaneous accept and pop loads the new event with no bubble.
//     Accept while evt_valid & !evt_ready: event dropped, overflow <= 1, register unchanged.
//   evt_* outputs remain stable while evt_valid & !evt_ready.
//   overflow: a set and clr_overflow in the same cycle -> set wins.
//   Reset mid-event: everything returns to reset values asynchronously; a pending
//     event is lost; level restarts at 0 even if the pad is high (first edge after
//     release is reported as a rising edge).
// STRUCTURE
//   Package iob_rx_pkg: typedef struct {logic rise; logic [TS_WIDTH-1:0] ts;}
//     iob_evt_t; filter state enum {FLT_STABLE, FLT_QUALIFY}; default width constants.
//   Sub-module iob_sync_chain (SYNC_STAGES, async-low reset) instantiated once.
//   Top: filter FSM, timestamp counter, event register, edge counter, overflow flag.
// TESTING
//   1 Reset, hold paddi=1, en=1, evt_ready=1 -> level=1 at cycle 6 (2+4),
//     evt_rise=1, edge_count=1, evt_ts = ts at acceptance.
//   2 Pulse paddi high for 3 cycles (FILTER_CYCLES=4) -> no level change,
//     evt_valid stays 0, edge_count=0.
//   3 evt_ready=0; apply two clean edges -> first event held with evt_rise=1,
//     second dropped, overflow=1, edge_count=2; pulse clr_overflow -> overflow=0.
//   4 Accept an edge in the same cycle as pop (evt_valid & evt_ready) -> new event
//     loaded with no idle cycle, overflow stays 0.
//   5 Run 65 540 cycles, then apply an edge -> evt_ts reflects the wrapped value.
//     Force edge_count to 0xFFFF -> next edge gives 0x0000.
//   6 en=0 during a QUALIFY window -> filter returns to STABLE, no event;
//     assert rst_n low mid-QUALIFY -> all outputs 0 immediately.

Source files
------------

// File: rtl/iob_rx_pkg.sv
// Shared types and default widths for the IO receive-side edge capture block.
package iob_rx_pkg;

   localparam int unsigned SYNC_STAGES_DEF   = 2;
   localparam int unsigned FILTER_CYCLES_DEF = 4;
   localparam int unsigned TS_WIDTH_DEF      = 16;
   localparam int unsigned CNT_WIDTH_DEF     = 16;
   localparam int unsigned FCNT_WIDTH        = 8;

   typedef struct packed {
      logic                    rise;
      logic [TS_WIDTH_DEF-1:0] ts;
   } iob_evt_t;

   typedef enum logic {
      FLT_STABLE  = 1'b0,
      FLT_QUALIFY = 1'b1
   } flt_state_e;

endpackage

// File: rtl/iob_rx_edge_capture_sync.sv
// Multi-flop synchroniser bringing the asynchronous pad input into the clk domain.
module iob_sync_chain #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/iob_rx_edge_capture.sv
// Synchronises and glitch-filters PADDI and reports each accepted edge as a
// timestamped event on a valid/ready port with a sticky drop flag.
module iob_rx_edge_capture
   import iob_rx_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int unsigned FILTER_CYCLES = FILTER_CYCLES_DEF,
   parameter int unsigned TS_WIDTH      = TS_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH     = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 paddi,
   input  logic                 en,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic                 evt_rise,
   output logic [TS_WIDTH-1:0]  evt_ts,
   output logic                 level,
   output logic [CNT_WIDTH-1:0] edge_count,
   output logic                 overflow,
   input  logic                 clr_overflow
);

   logic                  s;
   flt_state_e            state_q, state_d;
   logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
   logic                  level_q, level_d;
   logic [TS_WIDTH-1:0]   ts_q;
   logic                  evt_valid_q, evt_valid_d;
   logic                  evt_rise_q, evt_rise_d;
   logic [TS_WIDTH-1:0]   evt_ts_q, evt_ts_d;
   logic [CNT_WIDTH-1:0]  edge_count_q, edge_count_d;
   logic                  overflow_q, overflow_d;
   logic                  changed_c, done_c, accept_c;

   iob_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (paddi),
      .q_o   (s)
   );

   assign changed_c = (s != level_q);
   assign done_c    = (fcnt_q == FCNT_WIDTH'(FILTER_CYCLES - 1));

   // Filter state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FLT_STABLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Filter next state; single-cycle filtering never needs to qualify
   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = FLT_STABLE;
      end else begin
         case (state_q)
            FLT_STABLE:  if (changed_c && (FILTER_CYCLES > 1)) state_d = FLT_QUALIFY;
            FLT_QUALIFY: if (!changed_c || done_c) state_d = FLT_STABLE;
            default:     state_d = FLT_STABLE;
         endcase
      end
   end

   // Filter counter, acceptance and event bookkeeping
   always_comb begin
      accept_c     = 1'b0;
      fcnt_d       = fcnt_q;
      level_d      = level_q;
      evt_valid_d  = evt_valid_q;
      evt_rise_d   = evt_rise_q;
      evt_ts_d     = evt_ts_q;
      edge_count_d = edge_count_q;
      overflow_d   = overflow_q & ~clr_overflow;

      if (!en) begin
         fcnt_d = '0;
      end else begin
         case (state_q)
            FLT_STABLE: begin
               if (changed_c) begin
                  if (FILTER_CYCLES == 1) accept_c = 1'b1;
                  else                    fcnt_d   = FCNT_WIDTH'(1);
               end
            end
            FLT_QUALIFY: begin
               if (!changed_c) begin
                  fcnt_d = '0;
               end else if (done_c) begin
                  accept_c = 1'b1;
                  fcnt_d   = '0;
               end else begin
                  fcnt_d = fcnt_q + FCNT_WIDTH'(1);
               end
            end
            default: fcnt_d = '0;
         endcase
      end

      if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;

      // A pop in the same cycle frees the register for the new event
      if (accept_c) begin
         level_d      = s;
         edge_count_d = edge_count_q + CNT_WIDTH'(1);
         if (!evt_valid_q || evt_ready) begin
            evt_valid_d = 1'b1;
            evt_rise_d  = s;
            evt_ts_d    = ts_q;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q       <= '0;
         level_q      <= 1'b0;
         ts_q         <= '0;
         evt_valid_q  <= 1'b0;
         evt_rise_q   <= 1'b0;
         evt_ts_q     <= '0;
         edge_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         fcnt_q       <= fcnt_d;
         level_q      <= level_d;
         ts_q         <= ts_q + TS_WIDTH'(1);
         evt_valid_q  <= evt_valid_d;
         evt_rise_q   <= evt_rise_d;
         evt_ts_q     <= evt_ts_d;
         edge_count_q <= edge_count_d;
         overflow_q   <= overflow_d;
      end
   end

   assign evt_valid  = evt_valid_q;
   assign evt_rise   = evt_rise_q;
   assign evt_ts     = evt_ts_q;
   assign level      = level_q;
   assign edge_count = edge_count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_iob_rx_edge_capture.sv
// Directed bench for iob_rx_edge_capture with default parameters (2 sync, 4 filter).
module tb_iob_rx_edge_capture;

   logic        clk;
   logic        rst_n;
   logic        paddi;
   logic        en;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_rise;
   logic [15:0] evt_ts;
   logic        level;
   logic [15:0] edge_count;
   logic        overflow;
   logic        clr_overflow;

   int          n_cmp;
   int          n_err;
   logic [15:0] cyc;
   logic [15:0] c0;

   iob_rx_edge_capture dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .paddi        (paddi),
      .en           (en),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_rise     (evt_rise),
      .evt_ts       (evt_ts),
      .level        (level),
      .edge_count   (edge_count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference cycle count since reset release (the expected timestamp)
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 16'd0;
      else        cyc <= cyc + 16'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      paddi = 1'b1;
      en = 1'b1;
      evt_ready = 1'b1;
      clr_overflow = 1'b0;

      // 1: reset values, then pad held high gives a rising edge at cycle 6
      step(2);
      chk("rst_level", 32'(level), 32'h0);
      chk("rst_valid", 32'(evt_valid), 32'h0);
      chk("rst_count", 32'(edge_count), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      chk("rst_ts", 32'(evt_ts), 32'h0);
      rst_n = 1'b1;
      step(5);
      chk("t1_level_c5", 32'(level), 32'h0);
      step(1);
      chk("t1_level_c6", 32'(level), 32'h1);
      chk("t1_valid", 32'(evt_valid), 32'h1);
      chk("t1_rise", 32'(evt_rise), 32'h1);
      chk("t1_ts", 32'(evt_ts), 32'd5);
      chk("t1_count", 32'(edge_count), 32'h1);
      step(1);
      chk("t1_popped", 32'(evt_valid), 32'h0);

      // 2: 3-cycle glitch rejected; 4-cycle pulse accepted both ways
      rst_n = 1'b0;
      paddi = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(3);
      paddi = 1'b1;
      step(3);
      paddi = 1'b0;
      step(10);
      chk("t2_glitch_level", 32'(level), 32'h0);
      chk("t2_glitch_valid", 32'(evt_valid), 32'h0);
      chk("t2_glitch_count", 32'(edge_count), 32'h0);
      paddi = 1'b1;
      step(4);
      paddi = 1'b0;
      step(2);
      chk("t2_pulse_level", 32'(level), 32'h1);
      chk("t2_pulse_count", 32'(edge_count), 32'h1);
      step(6);
      chk("t2_fall_level", 32'(level), 32'h0);
      chk("t2_fall_count", 32'(edge_count), 32'h2);
      chk("t2_fall_rise", 32'(evt_rise), 32'h0);

      // 3: consumer stalled -> first event held, second dropped
      evt_ready = 1'b0;
      c0 = cyc;
      paddi = 1'b1;
      step(8);
      chk("t3_valid", 32'(evt_valid), 32'h1);
      chk("t3_rise", 32'(evt_rise), 32'h1);
      chk("t3_ts", 32'(evt_ts), 32'(16'(c0 + 16'd5)));
      paddi = 1'b0;
      step(8);
      chk("t3_drop_level", 32'(level), 32'h0);
      chk("t3_drop_ovf", 32'(overflow), 32'h1);
      chk("t3_drop_count", 32'(edge_count), 32'h4);
      chk("t3_held_valid", 32'(evt_valid), 32'h1);
      chk("t3_held_rise", 32'(evt_rise), 32'h1);
      chk("t3_held_ts", 32'(evt_ts), 32'(16'(c0 + 16'd5)));
      clr_overflow = 1'b1;
      step(1);
      clr_overflow = 1'b0;
      chk("t3_clr_ovf", 32'(overflow), 32'h0);

      // 4: accept in the same cycle as a pop loads without a bubble
      c0 = cyc;
      paddi = 1'b1;
      step(5);
      evt_ready = 1'b1;
      step(1);
      chk("t4_valid", 32'(evt_valid), 32'h1);
      chk("t4_ts", 32'(evt_ts), 32'(16'(c0 + 16'd5)));
      chk("t4_ovf", 32'(overflow), 32'h0);
      chk("t4_count", 32'(edge_count), 32'h5);
      step(1);
      chk("t4_popped", 32'(evt_valid), 32'h0);

      // 5: timestamp wrap, then edge counter wrap
      step(65540);
      c0 = cyc;
      paddi = 1'b0;
      step(8);
      chk("t5_ts_wrap", 32'(evt_ts), 32'(16'(c0 + 16'd5)));
      chk("t5_rise", 32'(evt_rise), 32'h0);
      chk("t5_count", 32'(edge_count), 32'h6);
      force dut.edge_count_q = 16'hFFFF;
      step(1);
      release dut.edge_count_q;
      step(1);
      chk("t5_count_max", 32'(edge_count), 32'hFFFF);
      paddi = 1'b1;
      step(8);
      chk("t5_count_wrap", 32'(edge_count), 32'h0);
      chk("t5_level", 32'(level), 32'h1);
      paddi = 1'b0;
      step(8);
      chk("t5_level_low", 32'(level), 32'h0);

      // 6: en low mid-qualify aborts; re-enable restarts qualification
      paddi = 1'b1;
      step(3);
      en = 1'b0;
      step(5);
      chk("t6_dis_level", 32'(level), 32'h0);
      chk("t6_dis_count", 32'(edge_count), 32'h1);
      chk("t6_dis_valid", 32'(evt_valid), 32'h0);
      en = 1'b1;
      step(3);
      chk("t6_en_level_c3", 32'(level), 32'h0);
      step(1);
      chk("t6_en_level_c4", 32'(level), 32'h1);
      chk("t6_en_count", 32'(edge_count), 32'h2);

      // 6: reset mid-qualify clears everything asynchronously
      evt_ready = 1'b0;
      paddi = 1'b0;
      step(4);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_level", 32'(level), 32'h0);
      chk("t6_rst_valid", 32'(evt_valid), 32'h0);
      chk("t6_rst_rise", 32'(evt_rise), 32'h0);
      chk("t6_rst_ts", 32'(evt_ts), 32'h0);
      chk("t6_rst_count", 32'(edge_count), 32'h0);
      chk("t6_rst_ovf", 32'(overflow), 32'h0);
      step(1);
      paddi = 1'b1;
      rst_n = 1'b1;
      step(6);
      chk("t6_post_level", 32'(level), 32'h1);
      chk("t6_post_rise", 32'(evt_rise), 32'h1);
      chk("t6_post_ts", 32'(evt_ts), 32'd5);
      chk("t6_post_count", 32'(edge_count), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
